// File: rtl/match_event_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : match_event_counter                                        |
// | Description : Counts rising edges of the 1011 detector's z output into   |
// |               a 2-digit BCD tally (00-99) for the 7-segment driver,      |
// |               emits a one-cycle strobe per match and stretches each      |
// |               match into a visible LED pulse.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk           in   1  system clock, all logic on posedge               |
// |   reset_n       in   1  asynchronous active-low reset                     |
// |   z_in          in   1  match indication from the sequence detector      |
// |   clear         in   1  synchronous clear of count/overflow/LED          |
// |   count_bcd     out  8  {tens[7:4], ones[3:0]} BCD match count           |
// |   overflow      out  1  sticky, set by a match arriving at count 99      |
// |   event_strobe  out  1  one-cycle pulse per rising edge of z_in          |
// |   led           out  1  high while the stretch timer is nonzero          |
// | Parameters                                                               |
// |   STRETCH_CYCLES  LED on-time per match in clk cycles (>= 1)             |
// |   SATURATE        0: 99 wraps to 00, 1: count holds at 99                |
// +--------------------------------------------------------------------------+

module match_event_counter #(
  parameter int unsigned STRETCH_CYCLES = 5_000_000,
  parameter int unsigned SATURATE       = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       z_in,
  input  logic       clear,
  output logic [7:0] count_bcd,
  output logic       overflow,
  output logic       event_strobe,
  output logic       led
);

  localparam int unsigned          TIMER_W      = $clog2(STRETCH_CYCLES + 1);
  localparam logic [TIMER_W-1:0]   STRETCH_LOAD = TIMER_W'(STRETCH_CYCLES);
  localparam logic [TIMER_W-1:0]   TIMER_ONE    = TIMER_W'(1);
  localparam logic [7:0]           BCD_MAX      = 8'h99;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic               z_q;
  logic               strobe_q;
  logic [7:0]         count_q, count_d;
  logic               ovf_q,   ovf_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  logic               rise;
  logic [3:0]         ones, tens;
  logic               at_max;
  logic [7:0]         count_at_max;

  // ---------------------------------------------------------------------------
  // Edge detect. z_q resets to 1 so a z_in held high across reset release
  // is treated as an old level rather than a fresh match.
  // ---------------------------------------------------------------------------
  assign rise = z_in & ~z_q;

  assign ones   = count_q[3:0];
  assign tens   = count_q[7:4];
  assign at_max = (count_q == BCD_MAX);

  // Value the tally takes when a match arrives at 99.
  generate
    if (SATURATE != 0) begin : g_saturate
      assign count_at_max = BCD_MAX;
    end else begin : g_wrap
      assign count_at_max = 8'h00;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic for tally, overflow flag and stretch timer.
  // clear wins over a coincident rise: nothing is counted or reloaded, but
  // the strobe (driven separately from rise) still fires.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    timer_d = (timer_q != '0) ? (timer_q - TIMER_ONE) : timer_q;

    if (clear) begin
      count_d = 8'h00;
      ovf_d   = 1'b0;
      timer_d = '0;
    end else if (rise) begin
      // Retrigger extends the LED pulse from this match.
      timer_d = STRETCH_LOAD;
      if (at_max) begin
        ovf_d   = 1'b1;
        count_d = count_at_max;
      end else if (ones == 4'd9) begin
        // Tens cannot exceed 9 here because 99 is handled above.
        count_d = {tens + 4'd1, 4'h0};
      end else begin
        count_d = {tens, ones + 4'd1};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z_q      <= 1'b1;
      strobe_q <= 1'b0;
      count_q  <= 8'h00;
      ovf_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      z_q      <= z_in;
      strobe_q <= rise;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      timer_q  <= timer_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign count_bcd    = count_q;
  assign overflow     = ovf_q;
  assign event_strobe = strobe_q;
  assign led          = (timer_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_match_event_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_match_event_counter                                     |
// | Description : Scoreboard bench for match_event_counter. Two instances    |
// |               (wrapping and saturating) share stimulus; each expected    |
// |               {overflow, count} is queued when a rise is driven and      |
// |               popped by a monitor whenever event_strobe is seen.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_match_event_counter;

  localparam int unsigned STRETCH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       z_drv;
  logic       clear;
  logic       sel_det;
  logic       x;
  logic       z_in;

  logic [7:0] count0, count1;
  logic       ovf0, ovf1;
  logic       strobe0, strobe1;
  logic       led0, led1;

  // Reference 1011 detector with a registered z, as on the board.
  logic [3:0] sh;
  logic       zdet;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh   <= 4'h0;
      zdet <= 1'b0;
    end else begin
      sh   <= {sh[2:0], x};
      zdet <= ({sh[2:0], x} == 4'b1011);
    end
  end

  assign z_in = sel_det ? zdet : z_drv;

  match_event_counter #(.STRETCH_CYCLES(STRETCH), .SATURATE(0)) u_dut_wrap (
    .clk(clk), .reset_n(reset_n), .z_in(z_in), .clear(clear),
    .count_bcd(count0), .overflow(ovf0), .event_strobe(strobe0), .led(led0)
  );

  match_event_counter #(.STRETCH_CYCLES(STRETCH), .SATURATE(1)) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .z_in(z_in), .clear(clear),
    .count_bcd(count1), .overflow(ovf1), .event_strobe(strobe1), .led(led1)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected-value model: decimal tally per instance (0 = wrap, 1 = saturate).
  int         m_cnt [2];
  bit         m_ovf [2];
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  bit         z_prev;

  function automatic logic [7:0] to_bcd(input int c);
    return 8'(((c / 10) << 4) | (c % 10));
  endfunction

  task automatic model_event(input bit clr);
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        m_cnt[i] = 0;
        m_ovf[i] = 1'b0;
      end else if (m_cnt[i] == 99) begin
        m_ovf[i] = 1'b1;
        m_cnt[i] = (i == 1) ? 99 : 0;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
    q0.push_back({m_ovf[0], to_bcd(m_cnt[0])});
    q1.push_back({m_ovf[1], to_bcd(m_cnt[1])});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
    end
  endtask

  // One cycle of direct drive on z_in (and clear).
  task automatic step(input bit v, input bit clr);
    @(negedge clk);
    z_drv = v;
    clear = clr;
    if (v && !z_prev) model_event(clr);
    else if (clr)     model_reset();
    z_prev = v;
  endtask

  // One bit into the reference detector; exp_evt marks the bit completing 1011.
  task automatic xstep(input bit b, input bit exp_evt);
    @(negedge clk);
    x = b;
    if (exp_evt) model_event(1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pop and compare on every strobe; track LED activity.
  // ---------------------------------------------------------------------------
  int         cyc = 0;
  int         n_strobe0 = 0;
  int         last_t = 0;
  int         prev_t = 0;
  int         led_cnt = 0;
  int         led_rises = 0;
  logic       led_prev = 1'b0;
  logic [8:0] e;

  always @(negedge clk) begin
    cyc++;
    if (led0) led_cnt++;
    if (led0 && !led_prev) led_rises++;
    led_prev = led0;
    if (strobe0 === 1'b1) begin
      n_strobe0++;
      prev_t = last_t;
      last_t = cyc;
      if (q0.size() == 0) begin
        chk("sb_wrap_unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        chk("sb_wrap_count", {24'h0, count0}, {24'h0, e[7:0]});
        chk("sb_wrap_ovf",   {31'h0, ovf0},   {31'h0, e[8]});
      end
    end
    if (strobe1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("sb_sat_unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("sb_sat_count", {24'h0, count1}, {24'h0, e[7:0]});
        chk("sb_sat_ovf",   {31'h0, ovf1},   {31'h0, e[8]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int s_before;

  initial begin
    reset_n = 1'b0;
    z_drv   = 1'b1;
    clear   = 1'b0;
    sel_det = 1'b0;
    x       = 1'b0;
    z_prev  = 1'b1;
    model_reset();

    // Reset with z_in high: everything quiet.
    repeat (3) @(negedge clk);
    chk("rst_count",  {24'h0, count0}, 32'h00);
    chk("rst_ovf",    {31'h0, ovf0},   32'h0);
    chk("rst_strobe", {31'h0, strobe0}, 32'h0);
    chk("rst_led",    {31'h0, led0},   32'h0);
    chk("rst_count_sat", {24'h0, count1}, 32'h00);

    // Release with z_in still high: no event.
    reset_n = 1'b1;
    repeat (3) step(1'b1, 1'b0);
    chk("held_thru_rst_count",  {24'h0, count0}, 32'h00);
    chk("held_thru_rst_strobe", n_strobe0, 32'd0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Single match: one strobe, count 01, LED exactly STRETCH cycles.
    led_cnt   = 0;
    led_rises = 0;
    step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    chk("single_led_cycles", led_cnt, 32'd4);
    chk("single_count", {24'h0, count0}, 32'h01);
    chk("single_strobes", n_strobe0, 32'd1);

    // z_in held five cycles counts once.
    repeat (5) step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    chk("held_count", {24'h0, count0}, 32'h02);

    // Retrigger two cycles after first pulse: LED 2+4 cycles, continuous.
    led_cnt   = 0;
    led_rises = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    chk("retrig_count", {24'h0, count0}, 32'h04);
    chk("retrig_led_cycles", led_cnt, 32'd6);
    chk("retrig_led_rises", led_rises, 32'd1);

    // BCD carry and 99 boundary.
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("clr_count", {24'h0, count0}, 32'h00);
    repeat (9) begin step(1'b1, 1'b0); step(1'b0, 1'b0); end
    chk("bcd_09", {24'h0, count0}, 32'h09);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    chk("bcd_10", {24'h0, count0}, 32'h10);
    repeat (90) begin step(1'b1, 1'b0); step(1'b0, 1'b0); end
    chk("wrap_100_count", {24'h0, count0}, 32'h00);
    chk("wrap_100_ovf",   {31'h0, ovf0},   32'h1);
    chk("sat_100_count",  {24'h0, count1}, 32'h99);
    chk("sat_100_ovf",    {31'h0, ovf1},   32'h1);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    chk("wrap_101_count", {24'h0, count0}, 32'h01);
    chk("wrap_101_ovf_sticky", {31'h0, ovf0}, 32'h1);
    chk("sat_101_count",  {24'h0, count1}, 32'h99);

    // Clear coincident with a rise at count 05.
    repeat (4) begin step(1'b1, 1'b0); step(1'b0, 1'b0); end
    chk("pre_clr_count", {24'h0, count0}, 32'h05);
    s_before = n_strobe0;
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("clr_rise_count",  {24'h0, count0}, 32'h00);
    chk("clr_rise_ovf",    {31'h0, ovf0},   32'h0);
    chk("clr_rise_led",    {31'h0, led0},   32'h0);
    chk("clr_rise_strobe", n_strobe0 - s_before, 32'd1);
    chk("clr_rise_sat_ovf", {31'h0, ovf1},  32'h0);

    // Asynchronous reset in the middle of a stretch.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("pre_rst_led", {31'h0, led0}, 32'h1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_rst_led",   {31'h0, led0},   32'h0);
    chk("async_rst_count", {24'h0, count0}, 32'h00);
    model_reset();
    z_prev = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;

    // Chained with the reference detector.
    sel_det = 1'b1;
    xstep(1, 0); xstep(1, 0); xstep(0, 0); xstep(0, 0); xstep(1, 0);
    repeat (6) xstep(0, 0);
    chk("det_11001_count", {24'h0, count0}, 32'h00);
    xstep(1, 0); xstep(0, 0); xstep(1, 0); xstep(1, 1);
    xstep(1, 0); xstep(0, 0); xstep(1, 0); xstep(1, 1);
    repeat (6) xstep(0, 0);
    chk("det_1011x2_count", {24'h0, count0}, 32'h02);
    chk("det_strobe_gap", last_t - prev_t, 32'd4);

    // Every queued event must have been seen.
    repeat (5) @(negedge clk);
    chk("drain_wrap", q0.size(), 32'd0);
    chk("drain_sat",  q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
